// File: rtl/pagerank_accumulate_if.sv
// Purpose: partial-rank stream in, damped rank vector out, status flags.
// Latency: none (wiring only).
// Backpressure: in_ready stalls the stream, rank_ready holds the rank vector.
interface pagerank_accumulate_if #(
  parameter int unsigned NODES_IN_GRAPH = 32
);
  logic                                in_valid;
  logic                                in_ready;
  logic                                stream_start;
  logic                                stream_done;
  logic [NODES_IN_GRAPH-1:0][63:0]     in_data;
  logic [NODES_IN_GRAPH-1:0][63:0]     rank_out;
  logic                                rank_valid;
  logic                                rank_ready;
  logic                                beat_err;
  logic [15:0]                         iter_count;

  // Stream producer / rank consumer side.
  modport master (
    output in_valid, stream_start, stream_done, in_data, rank_ready,
    input  in_ready, rank_out, rank_valid, beat_err, iter_count
  );

  // Accumulator side.
  modport slave (
    input  in_valid, stream_start, stream_done, in_data, rank_ready,
    output in_ready, rank_out, rank_valid, beat_err, iter_count
  );
endinterface

// File: rtl/pagerank_accumulate.sv
// Purpose: sum per-thread partial ranks per node (saturating), then damp one node per cycle.
// Latency: rank_valid rises NODES_IN_GRAPH+1 cycles after the stream_done transfer.
// Backpressure: in_ready low during SCALE/OUTPUT; rank vector held until rank_ready.
module pagerank_accumulate #(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned NODES_IN_GRAPH = 32,
  parameter int unsigned DAMP_NUM       = 55705,
  parameter int unsigned DAMP_SHIFT     = 16,
  parameter logic [63:0] BASE_TERM      = 64'd0
) (
  input logic              clock,
  input logic              reset,
  pagerank_accumulate_if.slave bus
);

  localparam int NODE_W = $clog2(NODES_IN_GRAPH);
  localparam int IDX_W  = $clog2(NODES_IN_GRAPH + 1);
  localparam int CNT_W  = $clog2(NUM_HW_THREADS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_HW_THREADS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NODES_IN_GRAPH);
  localparam logic [80:0]      DAMP_W   = 81'(DAMP_NUM);
  localparam logic [81:0]      BASE_W   = 82'(BASE_TERM);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;

  state_t                          state, state_nxt;
  logic [NODES_IN_GRAPH-1:0][63:0] acc;
  logic [NODES_IN_GRAPH-1:0][63:0] rank_q;
  logic [CNT_W-1:0]                beat_cnt;
  logic [CNT_W-1:0]                cnt_inc;
  logic [IDX_W-1:0]                idx;
  logic [NODE_W-1:0]               rd_idx;
  logic [NODE_W-1:0]               wr_idx;
  logic [80:0]                     prod_q;
  logic [81:0]                     sum_w;
  logic [63:0]                     scaled;
  logic                            rank_valid_q;
  logic                            beat_err_q;
  logic [15:0]                     iter_q;
  logic                            in_ready_w;
  logic                            xfer;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? {64{1'b1}} : s[63:0];
  endfunction

  assign in_ready_w = (state == IDLE) || (state == ACCUM);
  assign xfer       = bus.in_valid && in_ready_w;
  // Beat count saturates one past the expected count so overruns stay visible.
  assign cnt_inc    = (beat_cnt > CNT_FULL) ? beat_cnt : beat_cnt + 1'b1;
  // Multiplier is registered, so the write address trails the read address by one.
  assign rd_idx     = NODE_W'(idx);
  assign wr_idx     = NODE_W'(idx - 1'b1);
  assign sum_w      = 82'(prod_q >> DAMP_SHIFT) + BASE_W;
  assign scaled     = (|sum_w[81:64]) ? {64{1'b1}} : sum_w[63:0];

  assign bus.in_ready   = in_ready_w;
  assign bus.rank_out   = rank_q;
  assign bus.rank_valid = rank_valid_q;
  assign bus.beat_err   = beat_err_q;
  assign bus.iter_count = iter_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (xfer && bus.stream_start) state_nxt = bus.stream_done ? SCALE : ACCUM;
      ACCUM:  if (xfer && bus.stream_done)  state_nxt = SCALE;
      SCALE:  if (idx == IDX_LAST)          state_nxt = OUTPUT;
      OUTPUT: if (bus.rank_ready)           state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Accumulate, scale and output datapath plus status counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      rank_q       <= '0;
      beat_cnt     <= '0;
      idx          <= '0;
      prod_q       <= '0;
      rank_valid_q <= 1'b0;
      beat_err_q   <= 1'b0;
      iter_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (xfer) begin
            if (bus.stream_start) begin
              acc      <= bus.in_data;
              beat_cnt <= CNT_ONE;
              if (bus.stream_done && (CNT_ONE != CNT_FULL)) beat_err_q <= 1'b1;
            end else begin
              beat_err_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          idx <= '0;
          if (xfer) begin
            if (bus.stream_start) begin
              acc        <= bus.in_data;
              beat_cnt   <= CNT_ONE;
              beat_err_q <= 1'b1;
            end else begin
              for (int n = 0; n < int'(NODES_IN_GRAPH); n++) begin
                acc[n] <= sat_add(acc[n], bus.in_data[n]);
              end
              beat_cnt <= cnt_inc;
              if (bus.stream_done) begin
                if (cnt_inc != CNT_FULL) beat_err_q <= 1'b1;
              end else if (beat_cnt >= CNT_FULL) begin
                beat_err_q <= 1'b1;
              end
            end
          end
        end
        SCALE: begin
          if (idx != IDX_LAST) begin
            idx    <= idx + 1'b1;
            prod_q <= 81'(acc[rd_idx]) * DAMP_W;
          end
          if (idx != '0) rank_q[wr_idx] <= scaled;
          if (idx == IDX_LAST) rank_valid_q <= 1'b1;
        end
        OUTPUT: begin
          if (bus.rank_ready) begin
            rank_valid_q <= 1'b0;
            iter_q       <= iter_q + 16'd1;
            acc          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
